mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter WAIT_STATES, default 1, SHALL set the number of idle cycles (0..7) between request acceptance and ack.
REQ-002 Parameter DEPTH, default 64, SHALL set the number of 16-bit words; the address width is 6 bits.
REQ-003 clock  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 req  input  1  SHALL be the processor access request, held high until ack is seen.
REQ-006 we  input  1  SHALL select a write (1) or a read (0); it is sampled at acceptance.
REQ-007 addr  input  6  SHALL be the word address; it is sampled at acceptance.
REQ-008 wdata  input  16  SHALL be the write data; it is sampled at acceptance.
REQ-009 ack  output  1  SHALL be a one-cycle completion pulse.
REQ-010 rdata  output  16  SHALL carry the response data; it is valid only while ack=1.
REQ-011 busy  output  1  SHALL be high whenever the FSM is not IDLE.

Function
REQ-012 The FSM SHALL have the states IDLE, WAIT, RESP, plus CLEAR when MEM_RESPONDER_CLEAR_EN is defined.
REQ-013 In IDLE with req=1, the block SHALL latch we/addr/wdata and go to WAIT, or go directly to RESP if WAIT_STATES=0.
REQ-014 In WAIT, a 3-bit counter SHALL count WAIT_STATES cycles, then the FSM SHALL go to RESP.
REQ-015 Latency SHALL be fixed: ack rises WAIT_STATES+1 cycles after the acceptance edge.
REQ-016 In RESP, ack SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE unconditionally.
REQ-017 For a read, rdata SHALL equal mem[latched addr] as sampled in RESP.
REQ-018 For a write, mem[latched addr] SHALL be written on the RESP edge, and rdata SHALL echo the latched wdata (write-through).
REQ-019 A req still high in the IDLE cycle after ack SHALL start a new transaction; back-to-back throughput is one access per WAIT_STATES+2 cycles.
REQ-020 Changes to req/we/addr/wdata while not in IDLE SHALL be ignored.
REQ-021 Outside RESP, ack=0 and rdata=16'h0000.
REQ-022 Address wrap SHALL NOT occur; all 6-bit addresses are valid when DEPTH=64.

Reset
REQ-023 When reset=1 on an edge, the FSM SHALL go to IDLE (or CLEAR), the counter SHALL be 0, ack=0, rdata=0, and busy SHALL follow the state.
REQ-024 Reset SHALL win over any simultaneous req.
REQ-025 Reset in WAIT SHALL abort the transaction: no memory write and no ack.
REQ-026 Without MEM_RESPONDER_CLEAR_EN, reset SHALL NOT alter the memory contents.

Configuration
REQ-027 With MEM_RESPONDER_CLEAR_EN defined:
- reset SHALL enter CLEAR and write 16'h0000 to one word per cycle, addresses 0..DEPTH-1;
- busy SHALL be 1 throughout CLEAR;
- req SHALL be ignored during CLEAR;
- the FSM SHALL enter IDLE after DEPTH cycles;
- a reset during CLEAR SHALL restart the clear from address 0.
REQ-028 With MEM_RESPONDER_CLEAR_EN undefined, the CLEAR state and its address counter SHALL NOT exist, and reset SHALL go directly to IDLE.

Structure
REQ-029 Package mem_pkg SHALL hold DATA_W=16, ADDR_W=6, DEPTH_DEF=64, and the state enum typedef mem_state_t.
REQ-030 Storage SHALL be a sub-module mem_array: DEPTH x 16 bits, synchronous write, combinational read; mem_responder holds only the FSM, counter and latches.

Verification
REQ-031 Reset pulse, then write addr=0, wdata=16'hA022 (WAIT_STATES=1) -> ack exactly 2 cycles after acceptance, rdata=16'hA022, busy high for 2 cycles.
REQ-032 Read addr=0 after REQ-031 -> ack with rdata=16'hA022; read addr=1 (never written, CLEAR_EN defined) -> rdata=16'h0000.
REQ-033 req held high for 3 transactions writing addr 2,3,4 -> exactly 3 ack pulses spaced 3 cycles apart, with no lost or duplicate writes.
REQ-034 Write addr=5, wdata=16'h1234 with reset asserted during WAIT -> no ack; a subsequent read of addr 5 returns its prior value (not 16'h1234).
REQ-035 With WAIT_STATES=0 -> ack 1 cycle after acceptance; with WAIT_STATES=7 -> ack 8 cycles after acceptance.
REQ-036 With CLEAR_EN defined, req issued during CLEAR -> ignored, busy=1 for 64 cycles, then the first accepted read of addr 63 returns 16'h0000.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared widths, default depth and FSM state type for the memory responder.
// The CLEAR state exists only when MEM_RESPONDER_CLEAR_EN is defined.
package mem_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned ADDR_W    = 6;
  localparam int unsigned DEPTH_DEF = 64;

`ifdef MEM_RESPONDER_CLEAR_EN
  typedef enum logic [1:0] {IDLE, WAIT, RESP, CLEAR} mem_state_t;
`else
  typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_state_t;
`endif

endpackage

// File: rtl/mem_array.sv
// Word storage for mem_responder: synchronous write, combinational read.
module mem_array
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Single write port, updated on the clock edge.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  // Asynchronous read of the addressed word.
  always_comb begin
    rdata = mem[raddr];
  end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency single-port memory responder: accepts a request in IDLE,
// waits WAIT_STATES cycles, then completes in RESP with a registered
// one-cycle ack. Optional macro MEM_RESPONDER_CLEAR_EN adds a CLEAR state
// entered on reset that zeroes every word, one per cycle.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned DEPTH       = DEPTH_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy
);

  localparam logic [2:0] CNT_LAST = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

  mem_state_t        state, state_next;
  logic [2:0]        cnt, cnt_next;
  logic              accept;
  logic              ack_next;
  logic [DATA_W-1:0] rdata_next;
  logic              we_l;
  logic [ADDR_W-1:0] addr_l;
  logic [DATA_W-1:0] wdata_l;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

`ifdef MEM_RESPONDER_CLEAR_EN
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);
  localparam mem_state_t        RST_STATE = CLEAR;
  logic [ADDR_W-1:0] clr_addr, clr_addr_next;
`else
  localparam mem_state_t        RST_STATE = IDLE;
`endif

  mem_array #(.DEPTH(DEPTH)) u_mem (
    .clock (clock),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (addr_l),
    .rdata (mem_rdata)
  );

  // State, wait counter and registered response outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RST_STATE;
      cnt   <= '0;
      ack   <= 1'b0;
      rdata <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      ack   <= ack_next;
      rdata <= rdata_next;
    end
  end

`ifdef MEM_RESPONDER_CLEAR_EN
  // Clear sweep address; a reset always restarts the sweep from word 0.
  always_ff @(posedge clock) begin
    if (reset) clr_addr <= '0;
    else       clr_addr <= clr_addr_next;
  end
`endif

  // Request fields captured at acceptance; later input changes are ignored.
  always_ff @(posedge clock) begin
    if (accept) begin
      we_l    <= we;
      addr_l  <= addr;
      wdata_l <= wdata;
    end
  end

  // Next-state, memory write control and response data selection.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    ack_next   = 1'b0;
    rdata_next = '0;
    mem_we     = 1'b0;
    mem_waddr  = addr_l;
    mem_wdata  = wdata_l;
`ifdef MEM_RESPONDER_CLEAR_EN
    clr_addr_next = clr_addr;
`endif
    case (state)
      IDLE: begin
        if (req) begin
          accept     = 1'b1;
          cnt_next   = '0;
          state_next = (WAIT_STATES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt == CNT_LAST) begin
          cnt_next   = '0;
          state_next = RESP;
        end else begin
          cnt_next = cnt + 3'd1;
        end
      end
      RESP: begin
        mem_we     = we_l;
        ack_next   = 1'b1;
        rdata_next = we_l ? wdata_l : mem_rdata;
        state_next = IDLE;
      end
`ifdef MEM_RESPONDER_CLEAR_EN
      CLEAR: begin
        mem_we        = 1'b1;
        mem_waddr     = clr_addr;
        mem_wdata     = '0;
        clr_addr_next = clr_addr + 1'b1;
        if (clr_addr == CLR_LAST) state_next = IDLE;
      end
`endif
      default: state_next = IDLE;
    endcase
    // Reset aborts any access in flight, including the RESP-edge write.
    if (reset) mem_we = 1'b0;
  end

  // Busy flag follows the state register.
  always_comb begin
    busy = (state != IDLE);
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder (main instance WAIT_STATES=1, plus
// WAIT_STATES=0 and WAIT_STATES=7 instances for latency). Honours
// MEM_RESPONDER_CLEAR_EN when defined for the whole build.
module tb_mem_responder;

  localparam int W   = 1;
  localparam int DEP = 64;

  logic        clock = 1'b0;
  logic        reset, req, we, req_b;
  logic [5:0]  addr;
  logic [15:0] wdata;
  logic        ack, busy, ack0, busy0, ack7, busy7;
  logic [15:0] rdata, rdata0, rdata7;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  mem_responder #(.WAIT_STATES(1), .DEPTH(64)) dut (
    .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .ack(ack), .rdata(rdata), .busy(busy));

  mem_responder #(.WAIT_STATES(0), .DEPTH(64)) dut_w0 (
    .clock(clock), .reset(reset), .req(req_b), .we(we), .addr(addr),
    .wdata(wdata), .ack(ack0), .rdata(rdata0), .busy(busy0));

  mem_responder #(.WAIT_STATES(7), .DEPTH(64)) dut_w7 (
    .clock(clock), .reset(reset), .req(req_b), .we(we), .addr(addr),
    .wdata(wdata), .ack(ack7), .rdata(rdata7), .busy(busy7));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level model of the main instance: a busy countdown per
  // access, memory as a plain array with per-word known flags.
  logic [15:0] mmem [DEP];
  bit          mknown [DEP];
  int          busy_left = 0;
  bit          has_txn = 0;
  bit          t_we;
  int          t_addr;
  logic [15:0] t_wdata;
  bit          model_on = 0;
  bit          e_ack = 0, e_busy = 0, e_rd_known = 1;
  logic [15:0] e_rdata = '0;

  always @(posedge clock) begin
    e_ack = 0;
    e_rdata = '0;
    e_rd_known = 1;
    if (reset) begin
      model_on = 1;
      has_txn = 0;
`ifdef MEM_RESPONDER_CLEAR_EN
      busy_left = DEP;
      for (int i = 0; i < DEP; i++) begin
        mmem[i] = '0;
        mknown[i] = 1;
      end
`else
      busy_left = 0;
`endif
    end else if (busy_left == 0) begin
      if (req) begin
        has_txn = 1;
        t_we = we;
        t_addr = int'(addr);
        t_wdata = wdata;
        busy_left = W + 1;
      end
    end else begin
      busy_left--;
      if (busy_left == 0 && has_txn) begin
        has_txn = 0;
        e_ack = 1;
        if (t_we) begin
          mmem[t_addr] = t_wdata;
          mknown[t_addr] = 1;
          e_rdata = t_wdata;
        end else begin
          e_rdata = mmem[t_addr];
          e_rd_known = mknown[t_addr];
        end
      end
    end
    e_busy = (busy_left > 0);
  end

  // Every-cycle comparison of the main instance against the model.
  always @(negedge clock) begin
    if (model_on) begin
      check("model_ack", 32'(ack), 32'(e_ack));
      check("model_busy", 32'(busy), 32'(e_busy));
      if (e_rd_known) check("model_rdata", 32'(rdata), 32'(e_rdata));
    end
  end

  task automatic txn(input bit w, input logic [5:0] a, input logic [15:0] d, input bit scramble,
                     output logic [15:0] rd, output int lat, output int bcnt);
    @(negedge clock);
    req = 1; we = w; addr = a; wdata = d;
    lat = -1; bcnt = 0; rd = '0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clock);
      if (busy) bcnt++;
      if (scramble) begin addr = ~a; wdata = ~d; we = ~w; end
      if (ack) begin rd = rdata; lat = n - 1; break; end
    end
    req = 0; we = 0;
    if (lat < 0) begin
      vectors++; miscompares++;
      $display("FAIL txn_timeout: got no ack, expected ack within 20 cycles");
    end
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 200; n++) begin
      if (!busy) return;
      @(negedge clock);
    end
    vectors++; miscompares++;
    $display("FAIL idle_timeout: busy still 1, expected 0 within 200 cycles");
  endtask

  task automatic lat_pair(input bit w, input logic [5:0] a, input logic [15:0] d,
                          output int l0, output int l7, output logic [15:0] r0, output logic [15:0] r7);
    @(negedge clock);
    req_b = 1; we = w; addr = a; wdata = d;
    l0 = -1; l7 = -1; r0 = '0; r7 = '0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clock);
      if (ack0 && l0 < 0) begin l0 = n - 1; r0 = rdata0; end
      if (ack7 && l7 < 0) begin l7 = n - 1; r7 = rdata7; end
      if (l0 >= 0 && l7 >= 0) break;
    end
    req_b = 0; we = 0;
    repeat (4) @(negedge clock);
  endtask

  logic [15:0] rd, r0, r7;
  int lat, bc, acks, last, k, l0, l7;

  initial begin
    reset = 1; req = 0; req_b = 0; we = 0; addr = '0; wdata = '0;
    repeat (2) @(negedge clock);
    check("reset_ack", 32'(ack), 32'(0));
    check("reset_rdata", 32'(rdata), 32'(0));
`ifdef MEM_RESPONDER_CLEAR_EN
    check("reset_busy", 32'(busy), 32'(1));
`else
    check("reset_busy", 32'(busy), 32'(0));
`endif
    reset = 0;
    wait_idle();

    // First write: latency 2, echo, busy for 2 cycles.
    txn(1, 6'd0, 16'hA022, 0, rd, lat, bc);
    check("wr0_latency", 32'(lat), 32'(2));
    check("wr0_echo", 32'(rd), 32'hA022);
    check("wr0_busy_cycles", 32'(bc), 32'(2));

    // Read back while scrambling inputs after acceptance.
    txn(0, 6'd0, 16'h0000, 1, rd, lat, bc);
    check("rd0_data", 32'(rd), 32'hA022);
    check("rd0_latency", 32'(lat), 32'(2));
`ifdef MEM_RESPONDER_CLEAR_EN
    txn(0, 6'd1, 16'h0000, 0, rd, lat, bc);
    check("rd1_cleared", 32'(rd), 32'h0000);
`else
    txn(1, 6'd1, 16'h00C1, 0, rd, lat, bc);
    txn(0, 6'd1, 16'h0000, 0, rd, lat, bc);
    check("rd1_data", 32'(rd), 32'h00C1);
`endif

    // Back-to-back writes with req held high.
    @(negedge clock);
    req = 1; we = 1; addr = 6'd2; wdata = 16'h2222; k = 0; last = -1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clock);
      if (ack) begin
        if (k > 0) check("b2b_spacing", 32'(n - last), 32'(3));
        last = n; k++;
        if (k == 3) begin req = 0; we = 0; end
        else begin addr = addr + 6'd1; wdata = wdata + 16'h1111; end
      end
    end
    check("b2b_ack_count", 32'(k), 32'(3));
    txn(0, 6'd2, 16'h0, 0, rd, lat, bc); check("b2b_rd2", 32'(rd), 32'h2222);
    txn(0, 6'd3, 16'h0, 0, rd, lat, bc); check("b2b_rd3", 32'(rd), 32'h3333);
    txn(0, 6'd4, 16'h0, 0, rd, lat, bc); check("b2b_rd4", 32'(rd), 32'h4444);

    // Reset during WAIT aborts the write to addr 5.
    txn(1, 6'd5, 16'h5555, 0, rd, lat, bc);
    @(negedge clock);
    req = 1; we = 1; addr = 6'd5; wdata = 16'h1234;
    @(negedge clock);
    check("abort_in_wait_busy", 32'(busy), 32'(1));
    reset = 1; req = 0; we = 0;
    @(negedge clock);
    reset = 0; acks = 0;
    for (int n = 0; n < 4; n++) begin
      if (ack) acks++;
      @(negedge clock);
    end
    check("abort_no_ack", 32'(acks), 32'(0));
    wait_idle();
    txn(0, 6'd5, 16'h0, 0, rd, lat, bc);
`ifdef MEM_RESPONDER_CLEAR_EN
    check("abort_rd5", 32'(rd), 32'h0000);
`else
    check("abort_rd5", 32'(rd), 32'h5555);
`endif

    // Reset wins over a simultaneous request.
    @(negedge clock);
    req = 1; we = 1; addr = 6'd6; wdata = 16'h6666; reset = 1;
    @(negedge clock);
    reset = 0; req = 0; we = 0;
`ifdef MEM_RESPONDER_CLEAR_EN
    check("reset_vs_req_busy", 32'(busy), 32'(1));
`else
    check("reset_vs_req_busy", 32'(busy), 32'(0));
`endif
    wait_idle();

    // Latency for WAIT_STATES=0 and WAIT_STATES=7.
    lat_pair(1, 6'd9, 16'h7E57, l0, l7, r0, r7);
    check("w0_wr_latency", 32'(l0), 32'(1));
    check("w7_wr_latency", 32'(l7), 32'(8));
    check("w0_wr_echo", 32'(r0), 32'h7E57);
    check("w7_wr_echo", 32'(r7), 32'h7E57);
    lat_pair(0, 6'd9, 16'h0000, l0, l7, r0, r7);
    check("w0_rd_data", 32'(r0), 32'h7E57);
    check("w7_rd_data", 32'(r7), 32'h7E57);

`ifdef MEM_RESPONDER_CLEAR_EN
    // Clear restart and req ignored while clearing.
    txn(1, 6'd63, 16'hBEEF, 0, rd, lat, bc);
    @(negedge clock); reset = 1;
    @(negedge clock); reset = 0;
    repeat (10) @(negedge clock);
    reset = 1;
    @(negedge clock);
    reset = 0; req = 1; we = 0; addr = 6'd63; bc = 0;
    for (int n = 0; n < 200; n++) begin
      if (!busy) break;
      bc++;
      @(negedge clock);
    end
    check("clear_busy_cycles", 32'(bc), 32'(64));
    lat = -1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clock);
      if (ack) begin rd = rdata; lat = n; break; end
    end
    req = 0;
    check("clear_rd63_acked", 32'(lat >= 0), 32'(1));
    check("clear_rd63_data", 32'(rd), 32'h0000);
    wait_idle();
`endif

    repeat (3) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time limit, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
